// File: rtl/dtc_seq_walker_if.sv
// Handshake and table-write bundle for dtc_seq_walker.
// master = feature source / result sink / table loader, slave = engine.
interface dtc_seq_walker_if #(
  parameter int N_FEAT  = 12,
  parameter int CLASS_W = 3,
  parameter int DEPTH   = 4
);
  localparam int FIDX_W = $clog2(N_FEAT);
  localparam int CFG_W  =
    (FIDX_W > CLASS_W) ? FIDX_W : CLASS_W;

  logic [N_FEAT-1:0]  inp;
  logic               in_valid;
  logic               in_ready;
  logic [CLASS_W-1:0] outp;
  logic               out_valid;
  logic               out_ready;
  logic               cfg_we;
  logic               cfg_sel;
  logic [DEPTH-1:0]   cfg_addr;
  logic [CFG_W-1:0]   cfg_wdata;
  logic               cfg_err;

  modport master (
    output inp, in_valid, out_ready,
    output cfg_we, cfg_sel, cfg_addr, cfg_wdata,
    input  in_ready, outp, out_valid, cfg_err
  );

  modport slave (
    input  inp, in_valid, out_ready,
    input  cfg_we, cfg_sel, cfg_addr, cfg_wdata,
    output in_ready, outp, out_valid, cfg_err
  );
endinterface

// File: rtl/dtc_seq_walker.sv
// Sequential decision-tree classifier, one tree level per clock.
// Optional macro DTC_PATH_EN adds path_o (decision bits, root in MSB).
module dtc_seq_walker #(
  parameter int N_FEAT  = 12,
  parameter int CLASS_W = 3,
  parameter int DEPTH   = 4
) (
  input  logic clk,
  input  logic rst_n,
  dtc_seq_walker_if.slave bus
`ifdef DTC_PATH_EN
  ,
  output logic [DEPTH-1:0] path_o
`endif
);
  localparam int FIDX_W = $clog2(N_FEAT);
  localparam int NNODE  = 2**DEPTH - 1;
  localparam int NLEAF  = 2**DEPTH;
  localparam int IW     = DEPTH + 1;
  localparam int LW     = $clog2(DEPTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WALK = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [N_FEAT-1:0]  feat_q, feat_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [LW-1:0]      lvl_q, lvl_d;
  logic [CLASS_W-1:0] outp_q, outp_d;
  logic               cfg_err_q, cfg_err_d;

  logic [FIDX_W-1:0]  node_q [NLEAF];
  logic [CLASS_W-1:0] leaf_q [NLEAF];

  logic [FIDX_W-1:0] fsel;
  logic              bit_b;
  logic [IW-1:0]     idx_nx;
  logic [DEPTH-1:0]  leaf_a;
  logic              last;
  logic              cfg_bad;
  logic              node_w;
  logic              leaf_w;

  assign fsel = node_q[idx_q[DEPTH-1:0]];

  // Out-of-range feature indices read as a left turn
  assign bit_b =
    ({1'b0, fsel} < (FIDX_W+1)'(N_FEAT))
      ? feat_q[fsel] : 1'b0;

  assign idx_nx = {idx_q[IW-2:0], 1'b0}
                + IW'(1) + IW'(bit_b);
  assign leaf_a = idx_nx[DEPTH-1:0]
                - DEPTH'(NNODE);
  assign last   = (lvl_q == LW'(DEPTH - 1));

  // Node address NNODE is the only illegal DEPTH-bit value
  assign cfg_bad = bus.cfg_we &&
    ((state_q == S_WALK) ||
     (!bus.cfg_sel &&
      bus.cfg_addr == DEPTH'(NNODE)));
  assign node_w = bus.cfg_we && !cfg_bad
               && !bus.cfg_sel;
  assign leaf_w = bus.cfg_we && !cfg_bad
               && bus.cfg_sel;
  assign cfg_err_d = cfg_bad;

`ifdef DTC_PATH_EN
  logic [DEPTH-1:0] pw_q, pw_d;
  logic [DEPTH-1:0] path_q, path_d;
  logic [DEPTH-1:0] pw_nx;

  assign pw_nx  = DEPTH'({pw_q, bit_b});
  assign path_o = path_q;
`endif

  always_comb begin
    state_d = state_q;
    feat_d  = feat_q;
    idx_d   = idx_q;
    lvl_d   = lvl_q;
    outp_d  = outp_q;
`ifdef DTC_PATH_EN
    pw_d    = pw_q;
    path_d  = path_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_d = S_WALK;
          feat_d  = bus.inp;
          idx_d   = '0;
          lvl_d   = '0;
`ifdef DTC_PATH_EN
          pw_d    = '0;
`endif
        end
      end
      S_WALK: begin
        idx_d = idx_nx;
        lvl_d = lvl_q + LW'(1);
`ifdef DTC_PATH_EN
        pw_d  = pw_nx;
`endif
        if (last) begin
          state_d = S_DONE;
          outp_d  = leaf_q[leaf_a];
`ifdef DTC_PATH_EN
          path_d  = pw_nx;
`endif
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      feat_q    <= '0;
      idx_q     <= '0;
      lvl_q     <= '0;
      outp_q    <= '0;
      cfg_err_q <= 1'b0;
`ifdef DTC_PATH_EN
      pw_q      <= '0;
      path_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      feat_q    <= feat_d;
      idx_q     <= idx_d;
      lvl_q     <= lvl_d;
      outp_q    <= outp_d;
      cfg_err_q <= cfg_err_d;
`ifdef DTC_PATH_EN
      pw_q      <= pw_d;
      path_q    <= path_d;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NLEAF; i++) begin
        node_q[i] <= '0;
        leaf_q[i] <= '0;
      end
    end else begin
      if (node_w)
        node_q[bus.cfg_addr] <=
          bus.cfg_wdata[FIDX_W-1:0];
      if (leaf_w)
        leaf_q[bus.cfg_addr] <=
          bus.cfg_wdata[CLASS_W-1:0];
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.outp      = outp_q;
  assign bus.cfg_err   = cfg_err_q;
endmodule
